// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential restoring divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  // Wide enough for any practical dividend; callers slice to their width.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, trial-subtract
module div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   r_in,
  input  logic                 q_msb,
  input  logic [DIVISOR_W-1:0] d,
  output logic [DIVISOR_W:0]   r_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] r_shift;
  logic [DIVISOR_W:0] d_ext;

  always_comb begin
    r_shift = {r_in[DIVISOR_W-1:0], q_msb};
    d_ext   = {1'b0, d};
    if (r_shift >= d_ext) begin
      r_out = r_shift - d_ext;
      q_bit = 1'b1;
    end else begin
      r_out = r_shift;
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int  DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int  DIVISOR_W  = DIVISOR_W_DEF,
  localparam int CNT_W      = $clog2(DIVIDEND_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] q_work_q, q_work_d;
  logic [DIVISOR_W-1:0]  d_work_q, d_work_d;
  logic [DIVISOR_W:0]    r_work_q, r_work_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    step_r;
  logic                  step_bit;

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .r_in (r_work_q),
    .q_msb(q_work_q[DIVIDEND_W-1]),
    .d    (d_work_q),
    .r_out(step_r),
    .q_bit(step_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_work_d    = q_work_q;
    d_work_d    = d_work_q;
    r_work_d    = r_work_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            q_work_d = dividend;
            d_work_d = divisor;
            r_work_d = '0;
            cnt_d    = CNT_W'(DIVIDEND_W);
            state_d  = RUN;
          end else begin
            // Zero divisor short-circuits straight to a flagged result.
            quotient_d  = DBZ_QUOTIENT[DIVIDEND_W-1:0];
            remainder_d = '0;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        r_work_d = step_r;
        q_work_d = {q_work_q[DIVIDEND_W-2:0], step_bit};
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quotient_d  = {q_work_q[DIVIDEND_W-2:0], step_bit};
          remainder_d = step_r[DIVISOR_W-1:0];
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_work_q    <= '0;
      d_work_q    <= '0;
      r_work_q    <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_work_q    <= q_work_d;
      d_work_q    <= d_work_d;
      r_work_q    <= r_work_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int passed = 0;
  int total  = 0;
  logic sweep_on = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } res_t;

  res_t exp_q[$];

  seq_restoring_divider dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [3:0] b);
    res_t m;
    m.a = a;
    m.b = b;
    if (b == 4'd0) begin
      m.q = 8'd255;
      m.r = 4'd0;
      m.z = 1'b1;
    end else begin
      m.q = 8'(int'(a) / int'(b));
      m.r = 4'(int'(a) % int'(b));
      m.z = 1'b0;
    end
    return m;
  endfunction

  // Scoreboard: every accepted operand pair yields exactly one result, in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("model_quotient", quotient, exp_q[0].q);
          chk("model_remainder", remainder, exp_q[0].r);
          chk("model_dbz", div_by_zero, exp_q[0].z);
          if (!exp_q[0].z)
            chk("identity", int'(quotient) * int'(exp_q[0].b) + int'(remainder), exp_q[0].a);
          if (out_ready) void'(exp_q.pop_front());
        end
        chk("ready_valid_exclusive", in_ready, 0);
      end
      if (in_valid && in_ready) exp_q.push_back(model(dividend, divisor));
    end
  end

  always @(posedge clk) begin
    if (sweep_on) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                        input logic [3:0] er, input logic ez, input int elat, input int hold,
                        input string tag);
    int n;
    int lat;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_accept_wait"}, n < 50, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_in_ready"}, in_ready, 0);
        chk({tag, "_hold_out_valid"}, out_valid, 1);
        chk({tag, "_hold_quotient"}, quotient, eq);
        chk({tag, "_hold_remainder"}, remainder, er);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_after_hs"}, out_valid, 0);
    chk({tag, "_in_ready_after_hs"}, in_ready, 1);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8, 0, "basic_200_7");
    run_op(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8, 0, "div_by_one");
    run_op(8'd3,   4'd15, 8'd0,   4'd3, 1'b0, 8, 0, "small_dividend");
    run_op(8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8, 0, "full_scale");
    run_op(8'd13,  4'd0,  8'd255, 4'd0, 1'b1, 0, 0, "div_zero");
    run_op(8'd100, 4'd9,  8'd11,  4'd1, 1'b0, 8, 5, "backpressure");

    dividend = 8'd77;
    divisor  = 4'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    chk("async_rst_dbz", div_by_zero, 0);
    chk("async_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    run_op(8'd77, 4'd5, 8'd15, 4'd2, 1'b0, 8, 0, "after_reset");

    sweep_on = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        dividend = 8'(a);
        divisor  = 4'(b);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        chk("sweep_accept_wait", n < 100, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweep_drain_wait", n < 100, 1);
    sweep_on = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b0;
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
